// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: a - b - b_in over N = WIDTH/DIGIT cycles,
// start/done handshake with borrow, signed overflow and zero flags.
module serial_subtractor #(
   parameter int WIDTH = 32,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             b_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             b_out,
   output logic             overflow,
   output logic             zero
);

   localparam int N  = WIDTH / DIGIT;
   localparam int KW = (N > 1) ? $clog2(N) : 1;
   localparam logic [KW-1:0] KLAST = KW'(N - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q;
   logic [KW-1:0]    k_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] res_q;
   logic             carry_q;
   logic             a_msb_q;
   logic             b_msb_q;
   logic             done_q;
   logic [WIDTH-1:0] diff_q;
   logic             b_out_q;
   logic             ovf_q;
   logic             zero_q;

   logic [DIGIT:0]   sum_d;
   logic [WIDTH-1:0] res_d;

   // Subtract as a + ~b + carry; carry is the inverted borrow.
   always_comb begin
      sum_d = {1'b0, a_q[DIGIT-1:0]}
            + {1'b0, ~b_q[DIGIT-1:0]}
            + {{DIGIT{1'b0}}, carry_q};
      res_d = (res_q >> DIGIT)
            | (WIDTH'(sum_d[DIGIT-1:0]) << (WIDTH - DIGIT));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         k_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         done_q  <= 1'b0;
         diff_q  <= '0;
         b_out_q <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  a_q     <= a;
                  b_q     <= b;
                  carry_q <= ~b_in;
                  a_msb_q <= a[WIDTH-1];
                  b_msb_q <= b[WIDTH-1];
                  res_q   <= '0;
                  k_q     <= '0;
                  state_q <= RUN;
               end
            end
            RUN: begin
               a_q     <= a_q >> DIGIT;
               b_q     <= b_q >> DIGIT;
               carry_q <= sum_d[DIGIT];
               res_q   <= res_d;
               k_q     <= k_q + KW'(1);
               if (k_q == KLAST) begin
                  state_q <= IDLE;
                  k_q     <= '0;
                  diff_q  <= res_d;
                  zero_q  <= (res_d == '0);
                  ovf_q   <= (a_msb_q != b_msb_q)
                          && (res_d[WIDTH-1] != a_msb_q);
                  b_out_q <= ~sum_d[DIGIT];
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy     = (state_q == RUN);
   assign done     = done_q;
   assign diff     = diff_q;
   assign b_out    = b_out_q;
   assign overflow = ovf_q;
   assign zero     = zero_q;

endmodule
